// File: rtl/cpu_fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding path.
// The forwarding unit and the EX operand muxes both use these select codes,
// so the encoding is defined in one place.
`timescale 1ns/1ps
package cpu_fwd_pkg;

    // Register-index width used when a block is not parameterised otherwise
    localparam int DEFAULT_REG_W = 4;

    // EX operand mux select type and codes (011..111 are never produced)
    typedef logic [2:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 3'b000;
    localparam fwd_sel_t FWD_EXMEM   = 3'b001;
    localparam fwd_sel_t FWD_MEMWB   = 3'b010;

endpackage

// File: rtl/fwd_match.sv
// Forwarding match for one EX source operand.
// Compares the source index against the destinations held in the EX/MEM and
// MEM/WB shadow stages and returns the operand mux select code.
// Ports:
//   src     in   source register index of the instruction in EX
//   mem_rd  in   destination of the instruction in MEM
//   mem_we  in   MEM instruction writes mem_rd
//   wb_rd   in   destination of the instruction in WB
//   wb_we   in   WB instruction writes wb_rd
//   sel     out  FWD_EXMEM / FWD_MEMWB / FWD_REGFILE
`timescale 1ns/1ps
module fwd_match
    import cpu_fwd_pkg::*;
#(
    parameter int REG_W = DEFAULT_REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    output fwd_sel_t         sel
);

    logic src_nz_s;
    logic match_mem_s;
    logic match_wb_s;

    // r0 is hardwired to zero, so it is never forwarded
    assign src_nz_s    = (src != {REG_W{1'b0}});
    assign match_mem_s = mem_we && (mem_rd == src) && src_nz_s;
    assign match_wb_s  = wb_we && (wb_rd == src) && src_nz_s;

    // Select encoding; the younger result in EX/MEM wins over MEM/WB
    always_comb begin
        if (match_mem_s) begin
            sel = FWD_EXMEM;
        end else if (match_wb_s) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REGFILE;
        end
    end

endmodule

// File: rtl/forward_select_unit.sv
// Forwarding select and load-use stall unit between ID and the EX operand muxes.
// Keeps shadow copies of the register fields of the instructions in EX, MEM
// and WB, drives the EX operand mux selects from those flops, raises a
// one-cycle load-use stall and counts stall cycles (saturating).
// Ports:
//   clk, rst                     core clock, asynchronous active-high reset
//   id_valid                     ID holds a real instruction
//   id_rs1, id_rs2, id_rd        register indices of the ID instruction
//   id_reg_write, id_mem_read    ID instruction writes id_rd / is a load
//   flush                        kill the ID instruction (branch taken)
//   sel_a, sel_b                 EX operand-A / operand-B mux selects
//   stall                        hold PC and IF/ID, bubble into EX
//   stall_count                  saturating count of stall cycles
`timescale 1ns/1ps
module forward_select_unit
    import cpu_fwd_pkg::*;
#(
    parameter int REG_W = DEFAULT_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [2:0]       sel_a,
    output logic [2:0]       sel_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } ex_entry_t;

    // The load flag only matters while the load sits in EX, so later stages drop it
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
    } late_entry_t;

    localparam ex_entry_t   EX_BUBBLE   = {($bits(ex_entry_t)){1'b0}};
    localparam late_entry_t LATE_BUBBLE = {($bits(late_entry_t)){1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_entry_t        ex_q_r;
    late_entry_t      mem_q_r;
    late_entry_t      wb_q_r;
    ex_entry_t        ex_next_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_count_r;
    fwd_sel_t         sel_a_s;
    fwd_sel_t         sel_b_s;

    // Load-use hazard: the load in EX has not produced data yet when ID reads it
    assign stall_s = id_valid && !flush && ex_q_r.ld && ex_q_r.we
                     && (ex_q_r.rd != {REG_W{1'b0}})
                     && ((ex_q_r.rd == id_rs1) || (ex_q_r.rd == id_rs2));

    // Next EX entry: the ID instruction, or a bubble when it is invalid, killed or held
    always_comb begin
        ex_next_s = EX_BUBBLE;
        if (id_valid && !flush && !stall_s) begin
            ex_next_s.rs1 = id_rs1;
            ex_next_s.rs2 = id_rs2;
            ex_next_s.rd  = id_rd;
            ex_next_s.we  = id_reg_write;
            ex_next_s.ld  = id_mem_read;
        end else begin
            ex_next_s = EX_BUBBLE;
        end
    end

    // Shadow pipeline advancing one stage per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q_r  <= EX_BUBBLE;
            mem_q_r <= LATE_BUBBLE;
            wb_q_r  <= LATE_BUBBLE;
        end else begin
            ex_q_r     <= ex_next_s;
            mem_q_r.rd <= ex_q_r.rd;
            mem_q_r.we <= ex_q_r.we;
            wb_q_r     <= mem_q_r;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    fwd_match #(.REG_W(REG_W)) u_match_a (
        .src    (ex_q_r.rs1),
        .mem_rd (mem_q_r.rd),
        .mem_we (mem_q_r.we),
        .wb_rd  (wb_q_r.rd),
        .wb_we  (wb_q_r.we),
        .sel    (sel_a_s)
    );

    fwd_match #(.REG_W(REG_W)) u_match_b (
        .src    (ex_q_r.rs2),
        .mem_rd (mem_q_r.rd),
        .mem_we (mem_q_r.we),
        .wb_rd  (wb_q_r.rd),
        .wb_we  (wb_q_r.we),
        .sel    (sel_b_s)
    );

    assign sel_a       = sel_a_s;
    assign sel_b       = sel_b_s;
    assign stall       = stall_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: directed instruction streams,
// a history-based reference model checked every cycle, and literal checks
// at the interesting points of each scenario.
`timescale 1ns/1ps
module tb_forward_select_unit;

    localparam int TB_REG_W = 4;
    localparam int TB_CNT_W = 8;   // narrow counter so saturation is reachable quickly
    localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                id_valid = 1'b0;
    logic [TB_REG_W-1:0] id_rs1 = 4'd0;
    logic [TB_REG_W-1:0] id_rs2 = 4'd0;
    logic [TB_REG_W-1:0] id_rd = 4'd0;
    logic                id_reg_write = 1'b0;
    logic                id_mem_read = 1'b0;
    logic                flush = 1'b0;
    logic [2:0]          sel_a;
    logic [2:0]          sel_b;
    logic                stall;
    logic [TB_CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    forward_select_unit #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // issued[0] is the instruction that entered EX most recently,
    // issued[1] the one before (now in MEM), issued[2] (now in WB).
    typedef struct {
        bit we;
        bit ld;
        int rd;
        int rs1;
        int rs2;
    } instr_t;

    instr_t issued[$];
    int     exp_cnt = 0;

    function automatic instr_t bubble();
        instr_t b;
        b.we = 0; b.ld = 0; b.rd = 0; b.rs1 = 0; b.rs2 = 0;
        return b;
    endfunction

    function automatic int exp_sel(int src);
        if (src == 0) return 0;
        if (issued[1].we && issued[1].rd == src) return 1;
        if (issued[2].we && issued[2].rd == src) return 2;
        return 0;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) issued.push_back(bubble());
    end

    always @(negedge clk) begin
        int e_a, e_b;
        bit e_st;
        instr_t nx;
        if (rst) begin
            issued.delete();
            for (int i = 0; i < 3; i++) issued.push_back(bubble());
            exp_cnt = 0;
        end
        e_a  = exp_sel(issued[0].rs1);
        e_b  = exp_sel(issued[0].rs2);
        e_st = !rst && id_valid && !flush && issued[0].ld && issued[0].we && issued[0].rd != 0
               && (issued[0].rd == int'(id_rs1) || issued[0].rd == int'(id_rs2));
        chk("model sel_a", sel_a, e_a);
        chk("model sel_b", sel_b, e_b);
        chk("model stall", stall, e_st);
        chk("model stall_count", stall_count, exp_cnt);
        if (!rst) begin
            if (e_st && exp_cnt < CNT_SAT) exp_cnt = exp_cnt + 1;
            if (id_valid && !flush && !e_st) begin
                nx.we = id_reg_write; nx.ld = id_mem_read; nx.rd = int'(id_rd);
                nx.rs1 = int'(id_rs1); nx.rs2 = int'(id_rs2);
            end else begin
                nx = bubble();
            end
            issued.push_front(nx);
            void'(issued.pop_back());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                          input bit we, input bit ld, input bit fl);
        id_valid = v; id_rs1 = TB_REG_W'(rs1); id_rs2 = TB_REG_W'(rs2); id_rd = TB_REG_W'(rd);
        id_reg_write = we; id_mem_read = ld; flush = fl;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit we, input bit ld, input bit fl);
        @(posedge clk); #1;
        set_id(v, rs1, rs2, rd, we, ld, fl);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic look(input string name, input int ea, input int eb, input int est, input int ecnt);
        @(negedge clk);
        chk({name, " sel_a"}, sel_a, ea);
        chk({name, " sel_b"}, sel_b, eb);
        chk({name, " stall"}, stall, est);
        chk({name, " count"}, stall_count, ecnt);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #2;
        chk("reset sel_a", sel_a, 0);
        chk("reset stall", stall, 0);
        chk("reset count", stall_count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        look("post reset", 0, 0, 0, 0);

        // 1: add r1; add r2<-r1,r3 back to back
        nops(3);
        drive(1, 5, 6, 1, 1, 0, 0);
        drive(1, 1, 3, 2, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t1 exmem", 1, 0, 0, 0);

        // 2: add r1; nop; sub r4<-r5,r1
        nops(3);
        drive(1, 5, 6, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 1, 4, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t2 memwb", 0, 2, 0, 0);

        // 3: lw r2; add r6<-r2,r2 -> one stall, then 010 on both
        nops(3);
        drive(1, 5, 6, 2, 1, 1, 0);
        drive(1, 2, 2, 6, 1, 0, 0);
        look("t3 stall", 0, 0, 1, 0);
        drive(1, 2, 2, 6, 1, 0, 0);
        look("t3 held", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t3 fwd", 2, 2, 0, 1);

        // 4: r0 never forwarded; r3 in MEM and WB -> MEM wins
        nops(3);
        drive(1, 5, 6, 0, 1, 0, 0);
        drive(1, 0, 0, 7, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t4 r0", 0, 0, 0, 1);
        drive(1, 5, 6, 3, 1, 0, 0);
        drive(1, 5, 6, 3, 1, 0, 0);
        drive(1, 3, 3, 8, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t4 prio", 1, 1, 0, 1);

        // 5: load-use pair with flush in the consumer cycle
        nops(3);
        drive(1, 5, 6, 2, 1, 1, 0);
        drive(1, 2, 9, 6, 1, 0, 1);
        look("t5 flush", 0, 0, 0, 1);
        drive(1, 6, 6, 8, 1, 0, 0);
        look("t5 bubble", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        look("t5 no fwd", 0, 0, 0, 1);

        // 6: reset mid-stream with a pending forward and a pending stall
        nops(3);
        drive(1, 5, 6, 1, 1, 0, 0);
        drive(1, 1, 5, 2, 1, 1, 0);
        drive(1, 2, 3, 9, 1, 0, 0);
        #1;
        chk("t6 pre sel_a", sel_a, 1);
        chk("t6 pre stall", stall, 1);
        chk("t6 pre count", stall_count, 1);
        rst = 1'b1;
        #1;
        chk("t6 rst sel_a", sel_a, 0);
        chk("t6 rst sel_b", sel_b, 0);
        chk("t6 rst stall", stall, 0);
        chk("t6 rst count", stall_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        look("t6 first", 0, 0, 0, 0);

        // 6b: 2^CNT_W+5 stall cycles -> counter holds all-ones
        for (int i = 0; i < 2 * ((1 << TB_CNT_W) + 5); i++) drive(1, 2, 2, 2, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6 saturate", stall_count, CNT_SAT);

        nops(2);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
